clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Multi-channel, runtime-programmable clock-enable generator for the arcade video and game-logic paths. Each channel divides `clock_in` by its own divisor and emits both a one-cycle `tick_out` strobe and a duty-programmable `level_out` square wave. With `DIV=2` a channel produces the 25 MHz VGA pixel enable from 50 MHz; other channels serve as game-tick and blink timers. New divisor and duty values take effect only at a period boundary, so outputs never glitch or produce runt periods.

## Interface
- `CHANNELS`, 2: number of independent channels.
- `CNT_W`, 28: counter, divisor and high-count width.
- `DEFAULT_DIV`, 2: divisor loaded at reset (all channels).
- `DEFAULT_HIGH`, 1: high-count loaded at reset (all channels).

- `clock_in`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  CHANNELS: per-channel run enable.
- `sync`  in  1: restart all channel counters in phase.
- `load`  in  CHANNELS: per-channel strobe capturing `div_in`/`high_in` slice.
- `div_in`  in  CHANNELS*CNT_W: divisor, channel k at bits [k*CNT_W +: CNT_W].
- `high_in`  in  CHANNELS*CNT_W: high-phase length in cycles, same packing.
- `tick_out`  out  CHANNELS: one-cycle strobe per period.
- `level_out`  out  CHANNELS: square wave, high for `high` cycles per period.
- `pending_out`  out  CHANNELS: shadow values captured, not yet applied.

## Operation
- Per channel, the state is: `cnt`, active `div_r`/`high_r`, shadow `div_s`/`high_s`, and `pend`.
- Effective divisor `d = max(div_r, 1)`. A value of 0 is treated as 1.
- Terminal condition `term = (cnt == d-1)`.
- Enabled cycle:
  - `cnt <= term ? 0 : cnt+1`
  - `tick_out <= term`
  - `level_out <= (cnt < high_r)`
- Disabled cycle: `cnt` and `level_out` hold; `tick_out <= 0`; shadow/pending logic still operates.
- `load[k]` stores the slice into the shadow and sets `pend`. Repeated loads before application overwrite the shadow; the last load wins.
- Application happens on an enabled cycle with `term`, while `pend` (or `load` in the same cycle) is set:
  - `div_r`/`high_r` take the shadow values.
  - If `load` is asserted in that cycle, the `div_in`/`high_in` values are applied directly (bypass).
  - `pend` clears.
- `sync` (all channels) forces `cnt <= 0` and `tick_out <= 0`, applies any pending or same-cycle load immediately, and clears `pend`. `level_out` updates normally that cycle. `sync` overrides `enable=0` for the counter reset only.
- Duty boundaries:
  - `high_r = 0`: `level_out` stays at 0.
  - `high_r >= d`: `level_out` stays at 1.
  - `d = 1`: `tick_out` is high every enabled cycle.
- `pending_out = pend`.

## Timing
- Reset values:
  - `cnt = 0`, `div_r = div_s = DEFAULT_DIV`, `high_r = high_s = DEFAULT_HIGH`, `pend = 0`.
  - `tick_out = 0`, `level_out = 0`, `pending_out = 0`.
- Reset dominates `sync`, `load` and `enable`, including in mid-period.
- Outputs are registered and reflect the counter value of the previous cycle (1-cycle latency).
- After reset with `enable` high and `d = 2`:
  - `tick_out` first rises 2 cycles after reset release, then every 2 cycles.
  - `level_out` is 1 from the first cycle and alternates thereafter.
- A load applied at a boundary governs the very next period. No period uses mixed old/new values.
- `pending_out` rises the cycle after `load` and falls the cycle after application.

## Structure
- Package `clock_gen_pkg` holds:
  - default constants (`CNT_W`, `DEFAULT_DIV`, `DEFAULT_HIGH`);
  - the divisor-clamp function `max(div,1)`.
- Sub-module `clock_enable_channel`: one channel with scalar ports. The top level is a generate loop over `CHANNELS` plus slice unpacking.

## Test plan
- Reset, `enable=11`, defaults → both `tick_out` pulse every 2nd cycle and `level_out` toggles 1,0,1,0. All outputs are 0 while `reset` is held.
- Channel 1: load `div=5`, `high=2` mid-period → `pending_out[1]` stays 1 until the current period ends. Then there are periods of exactly 5 cycles with `level_out` high for 2, and no short period.
- `div=0` and `div=1`, `high=1` → `tick_out` is high on every enabled cycle and `level_out` is constantly 1. `high=0` → `level_out` is constantly 0. `high=9`, `div=4` → `level_out` is constantly 1.
- `enable[0]` dropped for 3 cycles mid-period → `cnt` and `level_out` hold, `tick_out` is 0, and the period resumes without losing counts.
- Channels at `div=3` and `div=7`, then `sync` pulsed → both restart at `cnt=0`. The first ticks occur 3 and 7 cycles later, and a pending load is applied at the `sync`.
- `load` coincident with `term`, then `reset` asserted mid-period → the bypassed value is used in the next period. The reset returns `div` and `high` to their defaults and all outputs to 0.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared defaults and helpers for the clock-enable generator.
// Every divisor passes through clamp_div, so a divisor of 0 behaves like 1.
package clock_gen_pkg;

  localparam int CNT_W        = 28;
  localparam int DEFAULT_DIV  = 2;
  localparam int DEFAULT_HIGH = 1;

  // Wide enough for any counter width used by the channels
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] clamp_div(input logic [MAX_W-1:0] div);
    return (div == '0) ? MAX_W'(1) : div;
  endfunction

endpackage

// File: rtl/clock_enable_channel.sv
// One clock-enable channel: a period counter with a tick strobe and a duty-cycle level.
// New divisor and high-count values are held in a shadow copy until a period boundary or sync.
module clock_enable_channel #(
  parameter int CNT_W        = clock_gen_pkg::CNT_W,
  parameter int DEFAULT_DIV  = clock_gen_pkg::DEFAULT_DIV,
  parameter int DEFAULT_HIGH = clock_gen_pkg::DEFAULT_HIGH
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic             tick_out,
  output logic             level_out,
  output logic             pending_out
);
  import clock_gen_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_r_q, div_r_d;
  logic [CNT_W-1:0] high_r_q, high_r_d;
  logic [CNT_W-1:0] div_s_q, div_s_d;
  logic [CNT_W-1:0] high_s_q, high_s_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] last_cnt;
  logic             term;
  logic             apply;

  assign last_cnt = CNT_W'(clamp_div(MAX_W'(div_r_q)) - MAX_W'(1));
  assign term     = (cnt_q == last_cnt);
  // A same-cycle load counts as pending, so it can be applied directly.
  assign apply    = (pend_q | load) & (sync | (enable & term));

  always_comb begin
    cnt_d    = cnt_q;
    div_r_d  = div_r_q;
    high_r_d = high_r_q;
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    level_d  = level_q;

    if (load) begin
      div_s_d  = div_in;
      high_s_d = high_in;
      pend_d   = 1'b1;
    end

    if (enable) begin
      level_d = (cnt_q < high_r_q);
      tick_d  = term & ~sync;
      cnt_d   = term ? '0 : cnt_q + CNT_W'(1);
    end

    if (sync) begin
      cnt_d = '0;
    end

    if (apply) begin
      div_r_d  = load ? div_in  : div_s_q;
      high_r_d = load ? high_in : high_s_q;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q    <= '0;
      div_r_q  <= CNT_W'(DEFAULT_DIV);
      high_r_q <= CNT_W'(DEFAULT_HIGH);
      div_s_q  <= CNT_W'(DEFAULT_DIV);
      high_s_q <= CNT_W'(DEFAULT_HIGH);
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_r_q  <= div_r_d;
      high_r_q <= high_r_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      level_q  <= level_d;
    end
  end

  assign tick_out    = tick_q;
  assign level_out   = level_q;
  assign pending_out = pend_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: independent channels sharing one clock, reset and sync.
// Divisor and high-count buses are packed with channel k at bits [k*CNT_W +: CNT_W].
module clock_enable_gen #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = clock_gen_pkg::CNT_W,
  parameter int DEFAULT_DIV  = clock_gen_pkg::DEFAULT_DIV,
  parameter int DEFAULT_HIGH = clock_gen_pkg::DEFAULT_HIGH
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS*CNT_W-1:0] high_in,
  output logic [CHANNELS-1:0]       tick_out,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pending_out
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    clock_enable_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_ch (
      .clock_in    (clock_in),
      .reset       (reset),
      .enable      (enable[gi]),
      .sync        (sync),
      .load        (load[gi]),
      .div_in      (div_in[gi*CNT_W +: CNT_W]),
      .high_in     (high_in[gi*CNT_W +: CNT_W]),
      .tick_out    (tick_out[gi]),
      .level_out   (level_out[gi]),
      .pending_out (pending_out[gi])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a per-cycle scoreboard plus fixed-pattern checks.
module tb_clock_enable_gen;
  localparam int CH    = 2;
  localparam int CNT_W = 28;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     enable = '0;
  logic              sync = 1'b0;
  logic [CH-1:0]     load = '0;
  logic [CH*CNT_W-1:0] div_in = '0;
  logic [CH*CNT_W-1:0] high_in = '0;
  logic [CH-1:0]     tick_out, level_out, pending_out;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] tick;
    logic [1:0] level;
    logic [1:0] pend;
  } exp_t;

  exp_t sb_q[$];

  logic [CNT_W-1:0] m_cnt [CH];
  logic [CNT_W-1:0] m_div_r [CH];
  logic [CNT_W-1:0] m_high_r [CH];
  logic [CNT_W-1:0] m_div_s [CH];
  logic [CNT_W-1:0] m_high_s [CH];
  logic [CH-1:0]    m_tick, m_level, m_pend;

  clock_enable_gen #(
    .CHANNELS     (CH),
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (2),
    .DEFAULT_HIGH (1)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .enable      (enable),
    .sync        (sync),
    .load        (load),
    .div_in      (div_in),
    .high_in     (high_in),
    .tick_out    (tick_out),
    .level_out   (level_out),
    .pending_out (pending_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, evaluated on the inputs currently driven
  task automatic model_step();
    for (int k = 0; k < CH; k++) begin
      logic [CNT_W-1:0] di, hi, eff;
      logic at_end, do_apply;
      di = div_in[k*CNT_W +: CNT_W];
      hi = high_in[k*CNT_W +: CNT_W];
      eff = (m_div_r[k] == 0) ? CNT_W'(1) : m_div_r[k];
      at_end = (m_cnt[k] == eff - CNT_W'(1));
      if (reset) begin
        m_cnt[k] = '0;
        m_div_r[k] = CNT_W'(2);
        m_div_s[k] = CNT_W'(2);
        m_high_r[k] = CNT_W'(1);
        m_high_s[k] = CNT_W'(1);
        m_pend[k] = 1'b0;
        m_tick[k] = 1'b0;
        m_level[k] = 1'b0;
      end else begin
        do_apply = (sync || (enable[k] && at_end)) && (m_pend[k] || load[k]);
        if (enable[k]) m_level[k] = (m_cnt[k] < m_high_r[k]);
        m_tick[k] = !sync && enable[k] && at_end;
        if (sync) m_cnt[k] = '0;
        else if (enable[k]) m_cnt[k] = at_end ? '0 : m_cnt[k] + CNT_W'(1);
        if (load[k]) begin
          m_div_s[k] = di;
          m_high_s[k] = hi;
        end
        if (do_apply) begin
          m_div_r[k] = m_div_s[k];
          m_high_r[k] = m_high_s[k];
          m_pend[k] = 1'b0;
        end else if (load[k]) begin
          m_pend[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.tick = m_tick;
    e.level = m_level;
    e.pend = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_tick", 32'(tick_out), 32'(e.tick));
    chk("sb_level", 32'(level_out), 32'(e.level));
    chk("sb_pending", 32'(pending_out), 32'(e.pend));
    $display("[TB] t=%0t tick=%b level=%b pending=%b", $time, tick_out, level_out, pending_out);
  endtask

  task automatic set_ch(input int ch, input int dv, input int hv);
    div_in[ch*CNT_W +: CNT_W] = CNT_W'(dv);
    high_in[ch*CNT_W +: CNT_W] = CNT_W'(hv);
  endtask

  task automatic wait_tick(input int ch, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_out[ch] && n < lim);
    chk("wait_tick", 32'(tick_out[ch]), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] tm0, tm1, lm0, lm1;

    // Reset held: every output low
    enable = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outputs", {26'd0, tick_out, level_out, pending_out}, 32'd0);
    end
    reset = 1'b0;

    // Defaults: tick every 2nd cycle, level 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dflt_tick", 32'(tick_out), (i % 2 == 1) ? 32'd3 : 32'd0);
      chk("dflt_level", 32'(level_out), (i % 2 == 0) ? 32'd3 : 32'd0);
    end

    // Channel 1 mid-period load of div=5 high=2
    set_ch(1, 5, 2);
    load = 2'b10;
    step();
    load = 2'b00;
    chk("ld_pending_set", 32'(pending_out), 32'd2);
    step();
    chk("ld_pending_clr", 32'(pending_out), 32'd0);
    tm1 = '0;
    lm1 = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      tm1[i] = tick_out[1];
      lm1[i] = level_out[1];
    end
    chk("div5_tick_mask", 32'(tm1), 32'h210);
    chk("div5_level_mask", 32'(lm1), 32'h063);

    // Divisor/duty boundary cases on channel 0
    for (int c = 0; c < 4; c++) begin
      int dv, hv;
      dv = (c == 0) ? 0 : (c == 3) ? 4 : 1;
      hv = (c == 2) ? 0 : (c == 3) ? 9 : 1;
      set_ch(0, dv, hv);
      load = 2'b01;
      step();
      load = 2'b00;
      for (int i = 0; i < 8; i++) step();
      tm0 = '0;
      lm0 = '0;
      for (int i = 0; i < 8; i++) begin
        step();
        tm0[i] = tick_out[0];
        lm0[i] = level_out[0];
      end
      if (c == 3) begin
        chk("div4_tick_count", 32'($countones(tm0)), 32'd2);
        chk("high9_level", 32'(lm0), 32'hFF);
      end else begin
        chk("d1_tick_every", 32'(tm0), 32'hFF);
        chk("d1_level", 32'(lm0), (c == 2) ? 32'h00 : 32'hFF);
      end
    end

    // Enable drop mid-period: count and level hold, no ticks, no lost counts
    set_ch(0, 5, 2);
    load = 2'b01;
    step();
    load = 2'b00;
    for (int i = 0; i < 8; i++) step();
    wait_tick(0, 10, n);
    for (int i = 0; i < 3; i++) step();
    enable = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_tick", 32'(tick_out[0]), 32'd0);
      chk("dis_level_hold", 32'(level_out[0]), 32'd0);
    end
    enable = 2'b11;
    wait_tick(0, 10, n);
    chk("resume_count", 32'(n), 32'd2);

    // Pending loads applied at sync, channels restart in phase
    enable = 2'b00;
    set_ch(0, 3, 1);
    set_ch(1, 7, 3);
    load = 2'b11;
    step();
    load = 2'b00;
    chk("sync_pending_set", 32'(pending_out), 32'd3);
    enable = 2'b11;
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_pending_clr", 32'(pending_out), 32'd0);
    chk("sync_tick", 32'(tick_out), 32'd0);
    tm0 = '0; tm1 = '0; lm0 = '0; lm1 = '0;
    for (int i = 0; i < 7; i++) begin
      step();
      tm0[i] = tick_out[0];
      tm1[i] = tick_out[1];
      lm0[i] = level_out[0];
      lm1[i] = level_out[1];
    end
    chk("sync_tick_ch0", 32'(tm0), 32'b0100100);
    chk("sync_tick_ch1", 32'(tm1), 32'b1000000);
    chk("sync_level_ch0", 32'(lm0), 32'b1001001);
    chk("sync_level_ch1", 32'(lm1), 32'b0000111);

    // Load coincident with the terminal count is bypassed into the next period
    for (int i = 0; i < 6; i++) step();
    set_ch(1, 3, 1);
    load = 2'b10;
    step();
    load = 2'b00;
    chk("bypass_tick", 32'(tick_out[1]), 32'd1);
    chk("bypass_pending", 32'(pending_out[1]), 32'd0);
    tm1 = '0;
    lm1 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      tm1[i] = tick_out[1];
      lm1[i] = level_out[1];
    end
    chk("bypass_tick_mask", 32'(tm1), 32'b100100);
    chk("bypass_level_mask", 32'(lm1), 32'b001001);

    // Mid-period reset restores defaults
    step();
    reset = 1'b1;
    load = 2'b11;
    sync = 1'b1;
    step();
    chk("midrst_outputs", {26'd0, tick_out, level_out, pending_out}, 32'd0);
    load = 2'b00;
    sync = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_tick", 32'(tick_out), (i % 2 == 1) ? 32'd3 : 32'd0);
      chk("postrst_level", 32'(level_out), (i % 2 == 0) ? 32'd3 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
